mips_pipe_ctrl: RTL and testbench

Successor to the single-cycle decoder for the 5-stage MIPS pipeline. It decodes op/func in ID into a control word and carries that word through the ID/EX, EX/MEM and MEM/WB registers. It also produces load-use stall, branch/jump flush, PC-select and EX-stage forwarding selects. It sits beside the datapath; all pipeline register data paths stay in the datapath, and only control lives here.

---
 rtl/mips_pipe_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_mips_pipe_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mips_pipe_ctrl.sv
// Pipeline control for the 5-stage MIPS core: ID decode, ID/EX..MEM/WB control
// registers, load-use stall, branch/jump redirect and EX-stage forwarding selects.
module mips_pipe_ctrl #(
   parameter int unsigned REG_W     = 5,
   parameter int unsigned ALU_W     = 5,
   parameter bit          HAZARD_EN = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       op,
   input  logic [5:0]       func,
   input  logic [REG_W-1:0] rs,
   input  logic [REG_W-1:0] rt,
   input  logic [REG_W-1:0] rd,
   input  logic             zero_ex,
   output logic [ALU_W-1:0] ex_aluctrl,
   output logic [1:0]       ex_alusrc,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             mem_read,
   output logic             mem_write,
   output logic             wb_regwrite,
   output logic             wb_memtoreg,
   output logic [REG_W-1:0] wb_dest,
   output logic             stall,
   output logic             flush,
   output logic [1:0]       pc_src
);

   localparam logic [ALU_W-1:0] ALU_AND = ALU_W'(5'b00000);
   localparam logic [ALU_W-1:0] ALU_OR  = ALU_W'(5'b00001);
   localparam logic [ALU_W-1:0] ALU_ADD = ALU_W'(5'b00010);
   localparam logic [ALU_W-1:0] ALU_SUB = ALU_W'(5'b00110);
   localparam logic [ALU_W-1:0] ALU_NOR = ALU_W'(5'b01100);
   localparam logic [ALU_W-1:0] ALU_SLL = ALU_W'(5'b01101);
   localparam logic [ALU_W-1:0] ALU_SRL = ALU_W'(5'b01110);
   localparam logic [ALU_W-1:0] ALU_SRA = ALU_W'(5'b01111);
   localparam logic [ALU_W-1:0] ALU_SLT = ALU_W'(5'b10000);

   typedef struct packed {
      logic [ALU_W-1:0] aluctrl;
      logic [1:0]       alusrc;
      logic             memread;
      logic             memwrite;
      logic             regwrite;
      logic             memtoreg;
      logic             branch;
   } ctrl_t;

   ctrl_t            id_ctrl;
   logic [REG_W-1:0] id_dest;
   logic             id_reads_rt, id_j, id_jr;

   ctrl_t            idex_ctrl_d, idex_ctrl_q, exmem_ctrl_d, exmem_ctrl_q, memwb_ctrl_d, memwb_ctrl_q;
   logic [REG_W-1:0] idex_rs_d, idex_rs_q, idex_rt_d, idex_rt_q, idex_dest_d, idex_dest_q;
   logic [REG_W-1:0] exmem_dest_d, exmem_dest_q, memwb_dest_d, memwb_dest_q;
   logic             load_use, branch_taken;

   // ID decode; unknown encodings fall through as the shift-coded bubble
   always_comb begin
      id_ctrl         = '0;
      id_ctrl.aluctrl = ALU_SLL;
      id_dest         = '0;
      id_reads_rt     = 1'b0;
      id_j            = 1'b0;
      id_jr           = 1'b0;
      case (op)
         6'b000000: begin
            id_reads_rt = 1'b1;
            id_dest     = rd;
            case (func)
               6'b100000, 6'b100001: begin id_ctrl.aluctrl = ALU_ADD; id_ctrl.regwrite = 1'b1; end
               6'b100010, 6'b100011: begin id_ctrl.aluctrl = ALU_SUB; id_ctrl.regwrite = 1'b1; end
               6'b100100: begin id_ctrl.aluctrl = ALU_AND; id_ctrl.regwrite = 1'b1; end
               6'b100101: begin id_ctrl.aluctrl = ALU_OR;  id_ctrl.regwrite = 1'b1; end
               6'b100111: begin id_ctrl.aluctrl = ALU_NOR; id_ctrl.regwrite = 1'b1; end
               6'b101010: begin id_ctrl.aluctrl = ALU_SLT; id_ctrl.regwrite = 1'b1; end
               6'b000000: begin id_ctrl.aluctrl = ALU_SLL; id_ctrl.alusrc = 2'b10; id_ctrl.regwrite = 1'b1; end
               6'b000010: begin id_ctrl.aluctrl = ALU_SRL; id_ctrl.alusrc = 2'b10; id_ctrl.regwrite = 1'b1; end
               6'b000011: begin id_ctrl.aluctrl = ALU_SRA; id_ctrl.alusrc = 2'b10; id_ctrl.regwrite = 1'b1; end
               6'b001000: begin id_ctrl.aluctrl = ALU_AND; id_jr = 1'b1; end
               default: id_ctrl.aluctrl = ALU_SLL;
            endcase
         end
         6'b100011: begin
            id_ctrl.aluctrl  = ALU_ADD;
            id_ctrl.alusrc   = 2'b01;
            id_ctrl.memread  = 1'b1;
            id_ctrl.memtoreg = 1'b1;
            id_ctrl.regwrite = 1'b1;
            id_dest          = rt;
         end
         6'b101011: begin
            id_ctrl.aluctrl  = ALU_ADD;
            id_ctrl.alusrc   = 2'b01;
            id_ctrl.memwrite = 1'b1;
            id_reads_rt      = 1'b1;
         end
         6'b001000: begin
            id_ctrl.aluctrl  = ALU_ADD;
            id_ctrl.alusrc   = 2'b01;
            id_ctrl.regwrite = 1'b1;
            id_dest          = rt;
         end
         6'b000100: begin
            id_ctrl.aluctrl = ALU_SUB;
            id_ctrl.branch  = 1'b1;
            id_reads_rt     = 1'b1;
         end
         6'b000010: begin
            id_ctrl.aluctrl = ALU_AND;
            id_j            = 1'b1;
         end
         default: id_ctrl.aluctrl = ALU_SLL;
      endcase
      if (id_dest == '0) id_ctrl.regwrite = 1'b0;
   end

   // Hazard detection and PC redirect: taken branch > load-use stall > jump
   always_comb begin
      branch_taken = idex_ctrl_q.branch & zero_ex;
      load_use     = HAZARD_EN && idex_ctrl_q.memread && (idex_dest_q != '0) &&
                     ((idex_dest_q == rs) || (id_reads_rt && (idex_dest_q == rt)));
      stall        = load_use & ~branch_taken;
      flush        = branch_taken | ((id_j | id_jr) & ~stall);
      pc_src       = 2'b00;
      if (branch_taken)             pc_src = 2'b01;
      else if (stall)               pc_src = 2'b00;
      else if (id_j)                pc_src = 2'b10;
      else if (id_jr)               pc_src = 2'b11;
   end

   always_comb begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
      if (HAZARD_EN) begin
         if (exmem_ctrl_q.regwrite && (exmem_dest_q == idex_rs_q))      fwd_a = 2'b10;
         else if (memwb_ctrl_q.regwrite && (memwb_dest_q == idex_rs_q)) fwd_a = 2'b01;
         if (exmem_ctrl_q.regwrite && (exmem_dest_q == idex_rt_q))      fwd_b = 2'b10;
         else if (memwb_ctrl_q.regwrite && (memwb_dest_q == idex_rt_q)) fwd_b = 2'b01;
      end
   end

   // Stages always advance; a stall or taken branch injects a cleared word into ID/EX
   always_comb begin
      idex_ctrl_d  = id_ctrl;
      idex_rs_d    = rs;
      idex_rt_d    = rt;
      idex_dest_d  = id_dest;
      if (stall || branch_taken) begin
         idex_ctrl_d = '0;
         idex_rs_d   = '0;
         idex_rt_d   = '0;
         idex_dest_d = '0;
      end
      exmem_ctrl_d = idex_ctrl_q;
      exmem_dest_d = idex_dest_q;
      memwb_ctrl_d = exmem_ctrl_q;
      memwb_dest_d = exmem_dest_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idex_ctrl_q  <= '0;
         idex_rs_q    <= '0;
         idex_rt_q    <= '0;
         idex_dest_q  <= '0;
         exmem_ctrl_q <= '0;
         exmem_dest_q <= '0;
         memwb_ctrl_q <= '0;
         memwb_dest_q <= '0;
      end else begin
         idex_ctrl_q  <= idex_ctrl_d;
         idex_rs_q    <= idex_rs_d;
         idex_rt_q    <= idex_rt_d;
         idex_dest_q  <= idex_dest_d;
         exmem_ctrl_q <= exmem_ctrl_d;
         exmem_dest_q <= exmem_dest_d;
         memwb_ctrl_q <= memwb_ctrl_d;
         memwb_dest_q <= memwb_dest_d;
      end
   end

   assign ex_aluctrl  = idex_ctrl_q.aluctrl;
   assign ex_alusrc   = idex_ctrl_q.alusrc;
   assign mem_read    = exmem_ctrl_q.memread;
   assign mem_write   = exmem_ctrl_q.memwrite;
   assign wb_regwrite = memwb_ctrl_q.regwrite;
   assign wb_memtoreg = memwb_ctrl_q.memtoreg;
   assign wb_dest     = memwb_dest_q;

endmodule

// File: tb/tb_mips_pipe_ctrl.sv
// Directed self-checking bench for mips_pipe_ctrl: decode latency, forwarding,
// load-use stall, branch/jump priority, bubbles and reset squash.
module tb_mips_pipe_ctrl;
   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op, func;
   logic [4:0] rs, rt, rd;
   logic       zero_ex;
   logic [4:0] ex_aluctrl, wb_dest;
   logic [1:0] ex_alusrc, fwd_a, fwd_b, pc_src;
   logic       mem_read, mem_write, wb_regwrite, wb_memtoreg, stall, flush;

   int tests  = 0;
   int failed = 0;

   mips_pipe_ctrl #(.REG_W(5), .ALU_W(5), .HAZARD_EN(1'b1)) dut (
      .clk(clk), .reset(reset), .op(op), .func(func), .rs(rs), .rt(rt), .rd(rd),
      .zero_ex(zero_ex), .ex_aluctrl(ex_aluctrl), .ex_alusrc(ex_alusrc),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_read(mem_read), .mem_write(mem_write),
      .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg), .wb_dest(wb_dest),
      .stall(stall), .flush(flush), .pc_src(pc_src)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present an instruction in ID and let combinational outputs settle
   task automatic id(input logic [5:0] o, input logic [5:0] f,
                     input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
      op = o; func = f; rs = s; rt = t; rd = d;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic nop();
      id(6'h00, 6'h00, 5'd0, 5'd0, 5'd0);
   endtask

   initial begin
      reset = 1'b1; zero_ex = 1'b0;
      nop();
      tick(); tick();
      reset = 1'b0;
      #1;
      chk("rst_ex_aluctrl", 8'(ex_aluctrl), 8'h00);
      chk("rst_ex_alusrc",  8'(ex_alusrc),  8'h0);
      chk("rst_mem_read",   8'(mem_read),   8'h0);
      chk("rst_mem_write",  8'(mem_write),  8'h0);
      chk("rst_wb_regwrite",8'(wb_regwrite),8'h0);
      chk("rst_wb_dest",    8'(wb_dest),    8'h0);
      chk("rst_stall",      8'(stall),      8'h0);
      chk("rst_flush",      8'(flush),      8'h0);
      chk("rst_pc_src",     8'(pc_src),     8'h0);
      chk("rst_fwd_a",      8'(fwd_a),      8'h0);
      chk("rst_fwd_b",      8'(fwd_b),      8'h0);
      tick();
      chk("sll_ex_aluctrl", 8'(ex_aluctrl), 8'h0d);
      chk("sll_ex_alusrc",  8'(ex_alusrc),  8'h2);
      tick(); tick();
      chk("sll_r0_wb_regwrite", 8'(wb_regwrite), 8'h0);

      // ADD r3,r1,r2 ; SUB r4,r3,r1
      id(6'h00, 6'h20, 5'd1, 5'd2, 5'd3);
      tick();
      id(6'h00, 6'h22, 5'd3, 5'd1, 5'd4);
      chk("add_sub_no_stall", 8'(stall), 8'h0);
      tick();
      nop();
      chk("sub_fwd_a",      8'(fwd_a),      8'h2);
      chk("sub_fwd_b",      8'(fwd_b),      8'h0);
      chk("sub_ex_aluctrl", 8'(ex_aluctrl), 8'h06);
      tick();
      chk("add_wb_regwrite", 8'(wb_regwrite), 8'h1);
      chk("add_wb_dest",     8'(wb_dest),     8'h3);
      chk("add_wb_memtoreg", 8'(wb_memtoreg), 8'h0);
      tick();
      chk("sub_wb_dest", 8'(wb_dest), 8'h4);

      // LW r5,0(r1) ; ADD r6,r5,r2
      id(6'h23, 6'h00, 5'd1, 5'd5, 5'd0);
      tick();
      id(6'h00, 6'h20, 5'd5, 5'd2, 5'd6);
      chk("lu_stall",     8'(stall),     8'h1);
      chk("lu_flush",     8'(flush),     8'h0);
      chk("lu_pc_src",    8'(pc_src),    8'h0);
      chk("lw_ex_alusrc", 8'(ex_alusrc), 8'h1);
      tick();
      chk("lu_stall_once",   8'(stall),     8'h0);
      chk("lw_mem_read",     8'(mem_read),  8'h1);
      chk("bubble_ex_alusrc",8'(ex_alusrc), 8'h0);
      tick();
      nop();
      chk("lu_fwd_a",       8'(fwd_a),       8'h1);
      chk("lu_fwd_b",       8'(fwd_b),       8'h0);
      chk("bubble_mem_read",8'(mem_read),    8'h0);
      chk("lw_wb_memtoreg", 8'(wb_memtoreg), 8'h1);
      chk("lw_wb_dest",     8'(wb_dest),     8'h5);
      tick(); tick(); tick();

      // LW r7 ; BEQ r1,r2 ; ADD r8,r7,r7 squashed by the taken branch
      id(6'h23, 6'h00, 5'd1, 5'd7, 5'd0);
      tick();
      id(6'h04, 6'h00, 5'd1, 5'd2, 5'd0);
      chk("beq_id_no_stall", 8'(stall), 8'h0);
      tick();
      id(6'h00, 6'h20, 5'd7, 5'd7, 5'd8);
      zero_ex = 1'b1;
      #1;
      chk("br_pc_src",    8'(pc_src),     8'h1);
      chk("br_flush",     8'(flush),      8'h1);
      chk("br_stall",     8'(stall),      8'h0);
      chk("br_ex_aluctrl",8'(ex_aluctrl), 8'h06);
      tick();
      zero_ex = 1'b0;
      nop();
      chk("br_wb_lw_dest", 8'(wb_dest), 8'h7);
      tick(); tick();
      chk("squash_wb_regwrite", 8'(wb_regwrite), 8'h0);
      chk("squash_wb_dest",     8'(wb_dest),     8'h0);

      // Taken branch beats a J in ID; untaken branch lets JR through
      id(6'h04, 6'h00, 5'd1, 5'd2, 5'd0);
      tick();
      id(6'h02, 6'h00, 5'd3, 5'd4, 5'd5);
      zero_ex = 1'b1;
      #1;
      chk("br_over_j_pc_src", 8'(pc_src), 8'h1);
      tick();
      zero_ex = 1'b0;
      id(6'h04, 6'h00, 5'd1, 5'd2, 5'd0);
      chk("j_squashed_ex_aluctrl", 8'(ex_aluctrl), 8'h00);
      tick();
      id(6'h00, 6'h08, 5'd1, 5'd0, 5'd0);
      chk("jr_pc_src", 8'(pc_src), 8'h3);
      chk("jr_flush",  8'(flush),  8'h1);
      tick();
      nop(); tick(); tick(); tick();

      // J in ID during a load-use stall (J's rs field aliases the load dest)
      id(6'h23, 6'h00, 5'd1, 5'd9, 5'd0);
      tick();
      id(6'h02, 6'h00, 5'd9, 5'd0, 5'd0);
      chk("j_stall",        8'(stall),  8'h1);
      chk("j_stall_pc_src", 8'(pc_src), 8'h0);
      chk("j_stall_flush",  8'(flush),  8'h0);
      tick();
      chk("j_retry_stall",  8'(stall),  8'h0);
      chk("j_retry_pc_src", 8'(pc_src), 8'h2);
      chk("j_retry_flush",  8'(flush),  8'h1);
      tick();
      nop(); tick(); tick(); tick();

      // Unknown opcode 111111 with non-zero register fields
      id(6'h3f, 6'h20, 5'd5, 5'd5, 5'd5);
      tick();
      nop();
      chk("unk_ex_aluctrl", 8'(ex_aluctrl), 8'h0d);
      chk("unk_ex_alusrc",  8'(ex_alusrc),  8'h0);
      tick();
      chk("unk_mem_read",  8'(mem_read),  8'h0);
      chk("unk_mem_write", 8'(mem_write), 8'h0);
      tick();
      chk("unk_wb_regwrite", 8'(wb_regwrite), 8'h0);

      // SW then reset mid-stream squashes ADD r10 / ADD r11
      id(6'h2b, 6'h00, 5'd1, 5'd2, 5'd0);
      tick();
      id(6'h00, 6'h20, 5'd1, 5'd2, 5'd10);
      tick();
      id(6'h00, 6'h20, 5'd1, 5'd2, 5'd11);
      chk("sw_mem_write", 8'(mem_write), 8'h1);
      tick();
      reset = 1'b1;
      nop();
      tick();
      reset = 1'b0;
      #1;
      chk("mid_rst_wb_regwrite", 8'(wb_regwrite), 8'h0);
      chk("mid_rst_mem_write",   8'(mem_write),   8'h0);
      chk("mid_rst_ex_aluctrl",  8'(ex_aluctrl),  8'h00);
      chk("mid_rst_fwd_a",       8'(fwd_a),       8'h0);
      tick();
      chk("mid_rst_wb_r11", 8'(wb_regwrite), 8'h0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
